// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and default adder geometry.
package alu_pkg;

  // Value of the sub input that selects subtraction.
  localparam logic OP_SUB    = 1'b1;

  // Default operand width and segment width of the pipelined adder.
  localparam int   DEF_WIDTH = 8;
  localparam int   DEF_SEG   = 4;

endpackage

// File: rtl/adder_seg.sv
// One SEG-bit ripple-carry segment. Also exposes the carry into the MSB so
// the last segment can form signed overflow.
module adder_seg
  import alu_pkg::*;
#(
  parameter int W = DEF_SEG
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  // Bit-serial ripple; the carry into the top bit is captured on the way.
  always_comb begin
    logic c;
    c     = cin;
    sum   = '0;
    c_msb = cin;
    for (int i = 0; i < W; i++) begin
      if (i == W-1) c_msb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit. Stage 0 captures the operands (b already
// inverted for subtraction) and the effective carry; stage k adds segment k
// and hands partial sum and carry on. A result register after the last
// stage drives the outputs, so nothing on the output side is combinational
// from the inputs. The last stage only moves into the result register while
// the consumer is ready, so pipeline capacity is NSEG beats.
module pipe_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG;

  logic [NSEG-1:0]            v_q, adv, ld, c_q, c_nx, seg_co, seg_cm;
  logic [NSEG-1:0][WIDTH-1:0] a_q, b_q, s_q, a_nx, b_nx, s_nx;
  logic [NSEG-1:0][SEG-1:0]   seg_sum;
  logic [WIDTH-1:0]           res_sum;
  logic                       unused_bits;

  // Advance chain from the output back to stage 0; bubbles collapse.
  always_comb begin
    adv          = '0;
    ld           = '0;
    adv[NSEG-1]  = v_q[NSEG-1] & out_ready;
    for (int k = NSEG-2; k >= 0; k--) begin
      adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
    end
    ld[0] = in_valid & (~v_q[0] | adv[0]);
    for (int k = 1; k < NSEG; k++) begin
      ld[k] = adv[k-1];
    end
  end

  assign in_ready = ~v_q[0] | adv[0];

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    adder_seg #(.W(SEG)) u_seg (
      .a     (a_q[k][k*SEG +: SEG]),
      .b     (b_q[k][k*SEG +: SEG]),
      .cin   (c_q[k]),
      .sum   (seg_sum[k]),
      .cout  (seg_co[k]),
      .c_msb (seg_cm[k])
    );

    if (k == 0) begin : g_first
      // Subtraction runs as a + ~b + ~cin.
      assign a_nx[0] = a;
      assign b_nx[0] = (sub == OP_SUB) ? ~b : b;
      assign c_nx[0] = cin ^ (sub == OP_SUB);
      assign s_nx[0] = '0;
    end else begin : g_next
      assign a_nx[k] = a_q[k-1];
      assign b_nx[k] = b_q[k-1];
      assign c_nx[k] = seg_co[k-1];
      assign s_nx[k] = s_q[k-1] | (WIDTH'(seg_sum[k-1]) << ((k-1)*SEG));
    end
  end

  assign res_sum = s_q[NSEG-1] | (WIDTH'(seg_sum[NSEG-1]) << ((NSEG-1)*SEG));

  // Stage registers: load on transfer in, otherwise drain the valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      c_q <= '0;
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (ld[k]) begin
          v_q[k] <= 1'b1;
          a_q[k] <= a_nx[k];
          b_q[k] <= b_nx[k];
          s_q[k] <= s_nx[k];
          c_q[k] <= c_nx[k];
        end else if (adv[k]) begin
          v_q[k] <= 1'b0;
        end
      end
    end
  end

  // Result register; data only changes on load, so it holds under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv[NSEG-1]) begin
      out_valid <= 1'b1;
      sum       <= res_sum;
      cout      <= seg_co[NSEG-1];
      ovf       <= seg_cm[NSEG-1] ^ seg_co[NSEG-1];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Already-consumed operand segments and inner MSB carries are dead bits.
  assign unused_bits = ^{a_q, b_q, seg_cm};

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: 8/4 and 16/4 instances, arithmetic reference model
// with an in-order scoreboard, plus directed vectors with literal results.
module tb_pipe_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v8 = 0, rdy8, cin8 = 0, sub8 = 0, ov8, or8 = 1, co8, ovf8;
  logic [7:0]  a8 = 0, b8 = 0, s8;
  logic        v16 = 0, rdy16, cin16 = 0, sub16 = 0, ov16, or16 = 1, co16, ovf16;
  logic [15:0] a16 = 0, b16 = 0, s16;

  pipe_adder #(.WIDTH(8), .SEG(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
    .cout(co8), .ovf(ovf8));

  pipe_adder #(.WIDTH(16), .SEG(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
    .cout(co16), .ovf(ovf16));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, b,
                                        input logic cin, sub);
    int ua, ub, sa, sb, full, t, lim, ci;
    logic co, ov;
    logic [15:0] s;
    lim  = 1 << (w-1);
    ua   = int'(a) & (2*lim-1);
    ub   = int'(b) & (2*lim-1);
    ci   = cin ? 1 : 0;
    sa   = (ua >= lim) ? ua - 2*lim : ua;
    sb   = (ub >= lim) ? ub - 2*lim : ub;
    if (!sub) begin
      full = ua + ub + ci;  co = (full >= 2*lim);  t = sa + sb + ci;
    end else begin
      full = ua - ub - ci;  co = (full >= 0);      t = sa - sb - ci;
    end
    s  = 16'(full & (2*lim-1));
    ov = (t >= lim) || (t < -lim);
    return {ov, co, s};
  endfunction

  typedef struct {logic [15:0] sum; logic cout; logic ovf; int t;} exp_t;
  exp_t q8[$];
  exp_t q16[$];
  logic [7:0] got8[$];
  int c8 = 0, c16 = 0;
  logic held8 = 0, hc8, ho8, held16 = 0, hc16, ho16;
  logic [7:0] hs8;
  logic [15:0] hs16;

  // Scoreboard for the 8-bit instance.
  always @(negedge clk) begin
    exp_t e;
    logic [17:0] m;
    c8++;
    if (rst) begin
      q8.delete();
      held8 = 0;
      check("rst8_out_valid", ov8, 0);
      check("rst8_sum", s8, 0);
    end else begin
      if (held8) begin
        check("hold8_valid", ov8, 1);
        check("hold8_sum", s8, hs8);
        check("hold8_cout", co8, hc8);
        check("hold8_ovf", ovf8, ho8);
      end
      if (ov8 && or8) begin
        got8.push_back(s8);
        if (q8.size() == 0) check("spurious8", 1, 0);
        else begin
          e = q8.pop_front();
          check("model8_sum", s8, e.sum);
          check("model8_cout", co8, e.cout);
          check("model8_ovf", ovf8, e.ovf);
          check("model8_lat_min", (c8 - e.t - 1) >= 2, 1);
        end
      end
      if (v8 && rdy8) begin
        m = model(8, {8'h0, a8}, {8'h0, b8}, cin8, sub8);
        e.sum = m[15:0]; e.cout = m[16]; e.ovf = m[17]; e.t = c8;
        q8.push_back(e);
      end
      held8 = ov8 && !or8; hs8 = s8; hc8 = co8; ho8 = ovf8;
    end
  end

  // Scoreboard for the 16-bit instance.
  always @(negedge clk) begin
    exp_t e;
    logic [17:0] m;
    c16++;
    if (rst) begin
      q16.delete();
      held16 = 0;
      check("rst16_out_valid", ov16, 0);
      check("rst16_sum", s16, 0);
    end else begin
      if (held16) begin
        check("hold16_valid", ov16, 1);
        check("hold16_sum", s16, hs16);
        check("hold16_cout", co16, hc16);
        check("hold16_ovf", ovf16, ho16);
      end
      if (ov16 && or16) begin
        if (q16.size() == 0) check("spurious16", 1, 0);
        else begin
          e = q16.pop_front();
          check("model16_sum", s16, e.sum);
          check("model16_cout", co16, e.cout);
          check("model16_ovf", ovf16, e.ovf);
          check("model16_lat_min", (c16 - e.t - 1) >= 4, 1);
        end
      end
      if (v16 && rdy16) begin
        m = model(16, a16, b16, cin16, sub16);
        e.sum = m[15:0]; e.cout = m[16]; e.ovf = m[17]; e.t = c16;
        q16.push_back(e);
      end
      held16 = ov16 && !or16; hs16 = s16; hc16 = co16; ho16 = ovf16;
    end
  end

  // Offer one beat to the 8-bit instance until it transfers.
  task automatic put8(input logic [7:0] a, b, input logic c, s, output int stalls);
    logic ok;
    ok = 0;
    stalls = 0;
    v8 = 1; a8 = a; b8 = b; cin8 = c; sub8 = s;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = rdy8;
      @(posedge clk);
      #1;
      if (ok) break;
      stalls++;
    end
    v8 = 0;
    if (!ok) check("put8_timeout", 0, 1);
  endtask

  // Count negedges until out_valid shows on the 8-bit instance.
  task automatic wait8(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov8 && n < 30);
    if (!ov8) check("wait8_timeout", 0, 1);
  endtask

  initial begin
    int n, st, idx, acc, bud;
    logic ok;
    logic [7:0] bp_a [3];
    logic [7:0] bp_b [3];
    logic       bp_c [3];
    logic       bp_s [3];
    logic [15:0] corner [4];

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_in_ready8", rdy8, 1);
    check("reset_in_ready16", rdy16, 1);
    check("reset_out_valid8", ov8, 0);
    check("reset_sum8", s8, 0);
    check("reset_cout8", co8, 0);
    check("reset_ovf8", ovf8, 0);
    @(posedge clk); #1;

    // 0x7F + 0x01: signed overflow, 2-edge latency, one-cycle pulse
    put8(8'h7F, 8'h01, 0, 0, st);
    wait8(n);
    check("lat8_edges", n - 1, 2);
    check("add_ovf_sum", s8, 8'h80);
    check("add_ovf_cout", co8, 0);
    check("add_ovf_ovf", ovf8, 1);
    @(negedge clk);
    check("add_ovf_pulse", ov8, 0);
    @(posedge clk); #1;

    put8(8'h00, 8'h01, 0, 1, st);
    wait8(n);
    check("sub_borrow_sum", s8, 8'hFF);
    check("sub_borrow_cout", co8, 0);
    check("sub_borrow_ovf", ovf8, 0);
    @(posedge clk); #1;
    put8(8'h80, 8'h01, 0, 1, st);
    wait8(n);
    check("sub_ovf_sum", s8, 8'h7F);
    check("sub_ovf_cout", co8, 1);
    check("sub_ovf_ovf", ovf8, 1);
    @(posedge clk); #1;

    // back-to-back stream
    put8(8'hFF, 8'h01, 0, 0, st); check("stream_rdy0", st, 0);
    put8(8'h0F, 8'h01, 0, 0, st); check("stream_rdy1", st, 0);
    put8(8'h12, 8'h34, 0, 0, st); check("stream_rdy2", st, 0);
    wait8(n);
    check("stream0_sum", s8, 8'h00); check("stream0_cout", co8, 1);
    @(negedge clk);
    check("stream1_valid", ov8, 1); check("stream1_sum", s8, 8'h10); check("stream1_cout", co8, 0);
    @(negedge clk);
    check("stream2_valid", ov8, 1); check("stream2_sum", s8, 8'h46); check("stream2_cout", co8, 0);
    @(posedge clk); #1;
    got8.delete();

    // backpressure: three beats offered with out_ready low
    bp_a = '{8'h01, 8'h10, 8'h55};
    bp_b = '{8'h02, 8'h20, 8'h05};
    bp_c = '{1'b0, 1'b0, 1'b1};
    bp_s = '{1'b0, 1'b0, 1'b1};
    or8 = 0;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      if (idx < 3) begin
        v8 = 1; a8 = bp_a[idx]; b8 = bp_b[idx]; cin8 = bp_c[idx]; sub8 = bp_s[idx];
      end else v8 = 0;
      @(negedge clk);
      ok = rdy8 && v8;
      check("bp_sum_held", s8, 8'h46);
      @(posedge clk); #1;
      if (ok) idx++;
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready_low", rdy8, 0);
    or8 = 1;
    for (int i = 0; i < 8; i++) begin
      if (idx < 3) begin
        v8 = 1; a8 = bp_a[idx]; b8 = bp_b[idx]; cin8 = bp_c[idx]; sub8 = bp_s[idx];
      end else v8 = 0;
      @(negedge clk);
      ok = rdy8 && v8;
      @(posedge clk); #1;
      if (ok) idx++;
    end
    v8 = 0;
    check("bp_all_accepted", idx, 3);
    check("bp_drain_count", got8.size(), 3);
    if (got8.size() == 3) begin
      check("bp_drain0", got8[0], 8'h03);
      check("bp_drain1", got8[1], 8'h30);
      check("bp_drain2", got8[2], 8'h4F);
    end

    // async reset with two beats still in flight
    put8(8'h11, 8'h11, 0, 0, st);
    put8(8'h22, 8'h22, 0, 0, st);
    put8(8'h33, 8'h33, 0, 0, st);
    check("arst_pre_valid", ov8, 1);
    check("arst_pre_sum", s8, 8'h22);
    #1 rst = 1;
    #1;
    check("arst_out_valid", ov8, 0);
    check("arst_sum", s8, 0);
    check("arst_cout", co8, 0);
    check("arst_ovf", ovf8, 0);
    @(posedge clk); @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("arst_in_ready", rdy8, 1);
    for (int i = 0; i < 6; i++) begin
      check("arst_no_stale", ov8, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // 16-bit: carry through all four segments
    v16 = 1; a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1; sub16 = 0;
    @(negedge clk); ok = rdy16;
    @(posedge clk); #1 v16 = 0;
    check("w16_accept", ok, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!ov16 && n < 30);
    check("w16_lat_edges", n - 1, 4);
    check("w16_sum", s16, 16'h0000);
    check("w16_cout", co16, 1);
    check("w16_ovf", ovf16, 0);
    @(posedge clk); #1;

    // randomised 16-bit stream with random backpressure
    corner = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    acc = 0; bud = 0;
    while (acc < 200 && bud < 3000) begin
      v16   = ($urandom_range(0, 9) < 7);
      a16   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      b16   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      cin16 = 1'($urandom_range(0, 1));
      sub16 = 1'($urandom_range(0, 1));
      or16  = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (v16 && rdy16) acc++;
      @(posedge clk); #1;
      bud++;
    end
    v16 = 0; or16 = 1;
    check("rand16_accepted", acc, 200);
    bud = 0;
    while (q16.size() != 0 && bud < 20) begin @(negedge clk); bud++; end
    check("rand16_drained", q16.size(), 0);
    check("rand8_drained", q8.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
